// File: rtl/dm_access_arbiter_if.sv
// Bus bundle for the data-memory access arbiter.
// slave: arbiter side; master: requesters and memory side.
interface dm_access_arbiter_if;
    logic        cpuReq;
    logic        cpuWrite;
    logic [31:0] cpuAddress;
    logic [31:0] cpuWriteData;
    logic [31:0] cpuReadData;
    logic        cpuDone;
    logic        cpuStall;
    logic        dmaReq;
    logic        dmaWrite;
    logic [31:0] dmaAddress;
    logic [31:0] dmaWriteData;
    logic [31:0] dmaReadData;
    logic        dmaDone;
    logic        memEnable;
    logic        memWriteEnabled;
    logic [31:0] memAddress;
    logic [31:0] memWriteInput;
    logic [31:0] memReadResult;

    modport slave (
        input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
        input  dmaReq, dmaWrite, dmaAddress, dmaWriteData,
        input  memReadResult,
        output cpuReadData, cpuDone, cpuStall,
        output dmaReadData, dmaDone,
        output memEnable, memWriteEnabled,
        output memAddress, memWriteInput
    );

    modport master (
        output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
        output dmaReq, dmaWrite, dmaAddress, dmaWriteData,
        output memReadResult,
        input  cpuReadData, cpuDone, cpuStall,
        input  dmaReadData, dmaDone,
        input  memEnable, memWriteEnabled,
        input  memAddress, memWriteInput
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// Data-memory port arbiter: CPU (MEM stage) vs loader/debug DMA.
// Ports: clock, reset (async high), bus (cpu*/dma* requesters, mem*).
module dm_access_arbiter #(
    parameter int MEM_LATENCY  = 0,
    parameter int STREAK_LIMIT = 4
) (
    input logic                 clock,
    input logic                 reset,
    dm_access_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STREAK_LIMIT);
    localparam logic [2:0] LAT   = 3'(MEM_LATENCY);

    logic [1:0]  state;
    logic        owner_dma;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] cpu_rd_q;
    logic [31:0] dma_rd_q;
    logic [2:0]  cnt;
    logic [3:0]  streak;

    logic grant_dma;
    logic grant_cpu;
    logic capture;

    // DMA wins when the CPU is idle or has used up its streak.
    always_comb begin
        grant_dma = bus.dmaReq
                  & (~bus.cpuReq | (streak == LIMIT));
        grant_cpu = ~grant_dma & bus.cpuReq;
        capture   = 1'b0;
        if (state == ACCESS)
            capture = ~wr_q & (LAT == 3'd0);
        else if (state == WAIT)
            capture = (cnt == 3'd1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_dma <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rd_q  <= '0;
            dma_rd_q  <= '0;
            cnt       <= '0;
            streak    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_dma | grant_cpu) begin
                        owner_dma <= grant_dma;
                        wr_q    <= grant_dma ? bus.dmaWrite
                                             : bus.cpuWrite;
                        addr_q  <= grant_dma ? bus.dmaAddress
                                             : bus.cpuAddress;
                        wdata_q <= grant_dma ? bus.dmaWriteData
                                             : bus.cpuWriteData;
                        if (grant_cpu & bus.dmaReq)
                            streak <= (streak == LIMIT) ? streak
                                    : streak + 4'd1;
                        else
                            streak <= '0;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wr_q || LAT == 3'd0) begin
                        state <= DONE;
                    end else begin
                        cnt   <= LAT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (capture) begin
                if (owner_dma)
                    dma_rd_q <= bus.memReadResult;
                else
                    cpu_rd_q <= bus.memReadResult;
            end
        end
    end

    assign bus.memEnable       = (state == ACCESS);
    assign bus.memWriteEnabled = (state == ACCESS) & wr_q;
    assign bus.memAddress      = addr_q;
    assign bus.memWriteInput   = wdata_q;
    assign bus.cpuDone         = (state == DONE) & ~owner_dma;
    assign bus.dmaDone         = (state == DONE) & owner_dma;
    assign bus.cpuReadData     = cpu_rd_q;
    assign bus.dmaReadData     = dma_rd_q;
    assign bus.cpuStall        = bus.cpuReq & ~bus.cpuDone;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: two instances (latency 0 and 3)
// with a behavioural memory and a transaction-level scoreboard.
module tb_dm_access_arbiter;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    int lat_of [2] = '{0, 3};

    logic        creq [2];
    logic        cwr  [2];
    logic [31:0] caddr[2];
    logic [31:0] cwd  [2];
    logic        dreq [2];
    logic        dwr  [2];
    logic [31:0] daddr[2];
    logic [31:0] dwd  [2];
    logic [31:0] crd  [2];
    logic        cdone[2];
    logic        cstall[2];
    logic [31:0] drd  [2];
    logic        ddone[2];
    logic        men  [2];
    logic        mwe  [2];
    logic [31:0] maddr[2];
    logic [31:0] mwd  [2];
    logic [31:0] rr   [2];

    dm_access_arbiter_if b0 ();
    dm_access_arbiter_if b1 ();

    dm_access_arbiter #(.MEM_LATENCY(0), .STREAK_LIMIT(4)) dut0 (
        .clock(clock), .reset(reset), .bus(b0));
    dm_access_arbiter #(.MEM_LATENCY(3), .STREAK_LIMIT(4)) dut1 (
        .clock(clock), .reset(reset), .bus(b1));

    assign b0.cpuReq        = creq[0];
    assign b0.cpuWrite      = cwr[0];
    assign b0.cpuAddress    = caddr[0];
    assign b0.cpuWriteData  = cwd[0];
    assign b0.dmaReq        = dreq[0];
    assign b0.dmaWrite      = dwr[0];
    assign b0.dmaAddress    = daddr[0];
    assign b0.dmaWriteData  = dwd[0];
    assign b0.memReadResult = rr[0];
    assign crd[0]    = b0.cpuReadData;
    assign cdone[0]  = b0.cpuDone;
    assign cstall[0] = b0.cpuStall;
    assign drd[0]    = b0.dmaReadData;
    assign ddone[0]  = b0.dmaDone;
    assign men[0]    = b0.memEnable;
    assign mwe[0]    = b0.memWriteEnabled;
    assign maddr[0]  = b0.memAddress;
    assign mwd[0]    = b0.memWriteInput;

    assign b1.cpuReq        = creq[1];
    assign b1.cpuWrite      = cwr[1];
    assign b1.cpuAddress    = caddr[1];
    assign b1.cpuWriteData  = cwd[1];
    assign b1.dmaReq        = dreq[1];
    assign b1.dmaWrite      = dwr[1];
    assign b1.dmaAddress    = daddr[1];
    assign b1.dmaWriteData  = dwd[1];
    assign b1.memReadResult = rr[1];
    assign crd[1]    = b1.cpuReadData;
    assign cdone[1]  = b1.cpuDone;
    assign cstall[1] = b1.cpuStall;
    assign drd[1]    = b1.dmaReadData;
    assign ddone[1]  = b1.dmaDone;
    assign men[1]    = b1.memEnable;
    assign mwe[1]    = b1.memWriteEnabled;
    assign maddr[1]  = b1.memAddress;
    assign mwd[1]    = b1.memWriteInput;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: unwritten words return a fixed pattern.
    function automatic logic [31:0] pattern(int k, logic [5:0] idx);
        if (k == 0 && idx == 6'd4)
            return 32'hDEADBEEF;
        return 32'hC0DE0000 | (32'(k) << 8) | 32'(idx);
    endfunction

    bit          wv [2][64];
    logic [31:0] wm [2][64];
    logic [2:0]  pend1;
    logic [31:0] paddr1;

    function automatic logic [31:0] mrd(int k, logic [31:0] a);
        return wv[k][a[7:2]] ? wm[k][a[7:2]] : pattern(k, a[7:2]);
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mwe[k]) begin
                wv[k][maddr[k][7:2]] <= 1'b1;
                wm[k][maddr[k][7:2]] <= mwd[k];
            end
        end
    end

    // Latency-3 memory: data is valid only 3 cycles after the strobe.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend1  <= '0;
            paddr1 <= '0;
        end else if (men[1]) begin
            pend1  <= 3'd3;
            paddr1 <= maddr[1];
        end else if (pend1 != 3'd0) begin
            pend1 <= pend1 - 3'd1;
        end
    end

    always_comb begin
        rr[0] = mrd(0, maddr[0]);
        rr[1] = (pend1 == 3'd1) ? mrd(1, paddr1) : 32'hBAD0BAD0;
    end

    logic [31:0] exp_mem [2][64];
    logic [31:0] exp_crd [2];
    logic [31:0] exp_drd [2];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(int k, bit dma, bit req, bit wr,
                         logic [31:0] a, logic [31:0] d);
        if (dma) begin
            dreq[k] = req; dwr[k] = wr; daddr[k] = a; dwd[k] = d;
        end else begin
            creq[k] = req; cwr[k] = wr; caddr[k] = a; cwd[k] = d;
        end
    endtask

    task automatic txn(int k, bit dma, bit wr,
                       logic [31:0] a, logic [31:0] d, string tag);
        int cyc, en_cnt, we_cnt;
        bit got, other;
        logic [31:0] we_a, we_d;
        cyc = 0; en_cnt = 0; we_cnt = 0;
        got = 0; other = 0; we_a = '0; we_d = '0;
        drive(k, dma, 1'b1, wr, a, d);
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (men[k]) en_cnt++;
            if (mwe[k]) begin
                we_cnt++; we_a = maddr[k]; we_d = mwd[k];
            end
            if (dma ? cdone[k] : ddone[k]) other = 1;
            got = dma ? ddone[k] : cdone[k];
        end
        drive(k, dma, 1'b0, wr, a, d);
        if (wr)
            exp_mem[k][a[7:2]] = d;
        else if (dma)
            exp_drd[k] = exp_mem[k][a[7:2]];
        else
            exp_crd[k] = exp_mem[k][a[7:2]];
        chk({tag, " done_cycle"}, 32'(cyc), 32'(wr ? 2 : lat_of[k] + 2));
        chk({tag, " other_done"}, 32'(other), 32'd0);
        chk({tag, " enable_cnt"}, 32'(en_cnt), 32'd1);
        chk({tag, " wr_cnt"}, 32'(we_cnt), 32'(wr));
        if (wr) begin
            chk({tag, " wr_addr"}, we_a, a);
            chk({tag, " wr_data"}, we_d, d);
        end
        chk({tag, " cpu_rd"}, crd[k], exp_crd[k]);
        chk({tag, " dma_rd"}, drd[k], exp_drd[k]);
        tick();
    endtask

    task automatic chk_zero(string tag, int k);
        chk({tag, " memEnable"}, 32'(men[k]), 32'd0);
        chk({tag, " memWE"}, 32'(mwe[k]), 32'd0);
        chk({tag, " memAddress"}, maddr[k], 32'd0);
        chk({tag, " memWrInput"}, mwd[k], 32'd0);
        chk({tag, " cpuDone"}, 32'(cdone[k]), 32'd0);
        chk({tag, " dmaDone"}, 32'(ddone[k]), 32'd0);
        chk({tag, " cpuRd"}, crd[k], 32'd0);
        chk({tag, " dmaRd"}, drd[k], 32'd0);
    endtask

    initial begin
        int run, ndma, cyc, k;
        bit dma, wr, exp_dma;
        logic [5:0] idx;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            creq[i] = 0; cwr[i] = 0; caddr[i] = '0; cwd[i] = '0;
            dreq[i] = 0; dwr[i] = 0; daddr[i] = '0; dwd[i] = '0;
            exp_crd[i] = '0; exp_drd[i] = '0;
            for (int j = 0; j < 64; j++)
                exp_mem[i][j] = pattern(i, 6'(j));
        end

        // reset state
        tick();
        chk_zero("rst0", 0);
        chk_zero("rst1", 1);
        reset = 1'b0;
        tick();

        // latency-0 CPU read
        drive(0, 0, 1, 0, 32'h10, 32'h0);
        #1;
        chk("t1 stall c0", 32'(cstall[0]), 32'd1);
        chk("t1 enable c0", 32'(men[0]), 32'd0);
        tick();
        chk("t1 enable c1", 32'(men[0]), 32'd1);
        chk("t1 we c1", 32'(mwe[0]), 32'd0);
        chk("t1 addr c1", maddr[0], 32'h10);
        chk("t1 stall c1", 32'(cstall[0]), 32'd1);
        tick();
        chk("t1 done c2", 32'(cdone[0]), 32'd1);
        chk("t1 rdata", crd[0], 32'hDEADBEEF);
        chk("t1 stall c2", 32'(cstall[0]), 32'd0);
        drive(0, 0, 0, 0, 32'h10, 32'h0);
        exp_crd[0] = 32'hDEADBEEF;
        tick();
        chk("t1 done c3", 32'(cdone[0]), 32'd0);

        // latency-3 write then read back
        txn(1, 0, 1, 32'h20, 32'h12345678, "t2 write");
        txn(1, 0, 0, 32'h20, 32'h0, "t2 read");
        chk("t2 rdata", crd[1], 32'h12345678);

        // both requesters held: CPU streak then forced DMA
        drive(0, 0, 1, 0, 32'h0, 32'h0);
        drive(0, 1, 1, 0, 32'h4, 32'h0);
        run = 0;
        ndma = 0;
        for (int g = 0; g < 10; g++) begin
            exp_dma = (run == 4);
            cyc = 0;
            while (!(cdone[0] | ddone[0]) && cyc < 10) begin
                tick();
                cyc++;
            end
            if (g == 9) begin
                creq[0] = 0;
                dreq[0] = 0;
            end
            chk("t3 grant cycle", 32'(cyc), 32'd2);
            chk("t3 owner", 32'(ddone[0]), 32'(exp_dma));
            chk("t3 single done", 32'(cdone[0] & ddone[0]), 32'd0);
            if (ddone[0]) ndma++;
            if (exp_dma) begin
                run = 0;
                exp_drd[0] = exp_mem[0][1];
            end else begin
                run++;
                exp_crd[0] = exp_mem[0][0];
            end
            chk("t3 cpu rd", crd[0], exp_crd[0]);
            chk("t3 dma rd", drd[0], exp_drd[0]);
            tick();
        end
        chk("t3 dma grants", 32'(ndma), 32'd2);

        // DMA read; CPU request raised mid-access waits
        drive(0, 1, 1, 0, 32'h40, 32'h0);
        tick();
        chk("t4 enable c1", 32'(men[0]), 32'd1);
        chk("t4 addr c1", maddr[0], 32'h40);
        drive(0, 0, 1, 0, 32'h44, 32'h0);
        tick();
        exp_drd[0] = exp_mem[0][16];
        chk("t4 dma done", 32'(ddone[0]), 32'd1);
        chk("t4 dma rd", drd[0], exp_drd[0]);
        chk("t4 cpu done", 32'(cdone[0]), 32'd0);
        chk("t4 cpu rd", crd[0], exp_crd[0]);
        chk("t4 stall dma", 32'(cstall[0]), 32'd1);
        dreq[0] = 0;
        tick();
        chk("t4 idle enable", 32'(men[0]), 32'd0);
        chk("t4 idle stall", 32'(cstall[0]), 32'd1);
        tick();
        chk("t4 cpu enable", 32'(men[0]), 32'd1);
        chk("t4 cpu addr", maddr[0], 32'h44);
        tick();
        exp_crd[0] = exp_mem[0][17];
        chk("t4 cpu done2", 32'(cdone[0]), 32'd1);
        chk("t4 cpu rd2", crd[0], exp_crd[0]);
        creq[0] = 0;
        tick();

        // async reset during WAIT aborts the access
        drive(1, 0, 1, 0, 32'h24, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_zero("t5 rst", 1);
        chk_zero("t5 rst", 0);
        creq[1] = 0;
        for (int i = 0; i < 2; i++) begin
            exp_crd[i] = '0;
            exp_drd[i] = '0;
        end
        tick();
        chk("t5 no done", 32'(cdone[1]), 32'd0);
        reset = 1'b0;
        tick();
        chk("t5 idle done", 32'(cdone[1]), 32'd0);
        txn(1, 0, 0, 32'h20, 32'h0, "t5 after");
        chk("t5 rdata", crd[1], 32'h12345678);

        // chained CPU access with Req held across Done
        drive(0, 0, 1, 0, 32'h8, 32'h0);
        tick();
        tick();
        chk("t6 done1", 32'(cdone[0]), 32'd1);
        chk("t6 rd1", crd[0], exp_mem[0][2]);
        caddr[0] = 32'hC;
        chk("t6 done enable", 32'(men[0]), 32'd0);
        tick();
        chk("t6 idle enable", 32'(men[0]), 32'd0);
        chk("t6 idle done", 32'(cdone[0]), 32'd0);
        chk("t6 idle stall", 32'(cstall[0]), 32'd1);
        tick();
        chk("t6 enable2", 32'(men[0]), 32'd1);
        chk("t6 addr2", maddr[0], 32'hC);
        tick();
        exp_crd[0] = exp_mem[0][3];
        chk("t6 done2", 32'(cdone[0]), 32'd1);
        chk("t6 rd2", crd[0], exp_crd[0]);
        creq[0] = 0;
        tick();

        // randomized single-requester traffic on both instances
        for (int i = 0; i < 40; i++) begin
            k   = int'($urandom_range(0, 1));
            dma = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            idx = 6'($urandom_range(0, 63));
            txn(k, dma, wr, {24'h0, idx, 2'b00}, $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
